// File: rtl/pc_push_sequencer_if.sv
// pc_push_sequencer_if
//   Handshake and data-memory write bus between the control unit, the
//   pc_push_sequencer and the data-memory write port.
//   Optional feature macro: PC_PUSH_FLAGS_EN (adds the 4-bit flags field).
//   Signals:
//     call_req, int_req : push requests, level held until ack
//     ret_pc[31:0]      : return address, sampled in the accept cycle
//     flags[3:0]        : condition flags (PC_PUSH_FLAGS_EN only)
//     pop_req           : pop path consumed a two-word PC frame
//     ack               : accept pulse (combinational in IDLE)
//     busy              : push sequence in progress
//     mem_wr/mem_addr/mem_wdata : data-memory write port
//     sp                : current stack pointer (next free word)
//     done              : pulse coincident with the final write
//   Modports: master = control side, slave = sequencer.
interface pc_push_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 20
);
  logic                  call_req;
  logic                  int_req;
  logic [31:0]           ret_pc;
`ifdef PC_PUSH_FLAGS_EN
  logic [3:0]            flags;
`endif
  logic                  pop_req;
  logic                  ack;
  logic                  busy;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] sp;
  logic                  done;

  modport master (
    output call_req, int_req, ret_pc, pop_req,
`ifdef PC_PUSH_FLAGS_EN
    output flags,
`endif
    input  ack, busy, mem_wr, mem_addr, mem_wdata, sp, done
  );

  modport slave (
    input  call_req, int_req, ret_pc, pop_req,
`ifdef PC_PUSH_FLAGS_EN
    input  flags,
`endif
    output ack, busy, mem_wr, mem_addr, mem_wdata, sp, done
  );
endinterface

// File: rtl/pc_push_sequencer.sv
// pc_push_sequencer
//   Pushes the return PC (high word, then low word) and, for interrupts when
//   PC_PUSH_FLAGS_EN is defined, the flags word onto the data-memory stack.
//   Owns the stack pointer: decrements on each pushed word, +2 on pop_req.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-low reset
//     bus  : pc_push_sequencer_if.slave (requests, ack/busy/done, write port, sp)
//   Optional feature macro: PC_PUSH_FLAGS_EN.
module pc_push_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 20'hFFFFF
) (
  input  logic                clk,
  input  logic                rst,
  pc_push_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO
`ifdef PC_PUSH_FLAGS_EN
    , PUSH_FLG
`endif
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] sp_q;
  logic [31:0]           pc_q;
`ifdef PC_PUSH_FLAGS_EN
  logic [3:0]            flags_q;
  logic                  is_int_q;
`endif
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [15:0]           mem_wdata_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  accept;

  // Pop wins over any pending request; interrupts win over calls.
  assign accept = (state_q == IDLE) && !bus.pop_req &&
                  (bus.int_req || bus.call_req);

  assign bus.ack       = accept;
  assign bus.busy      = busy_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sp        = sp_q;
  assign bus.done      = done_q;

  // Write-port outputs are loaded one edge ahead of the state that owns the
  // write, so each state sees its own address/data already registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sp_q        <= SP_RESET;
      pc_q        <= '0;
`ifdef PC_PUSH_FLAGS_EN
      flags_q     <= '0;
      is_int_q    <= 1'b0;
`endif
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.pop_req) begin
            sp_q <= sp_q + ADDR_WIDTH'(2);
          end else if (accept) begin
            pc_q        <= bus.ret_pc;
`ifdef PC_PUSH_FLAGS_EN
            flags_q     <= bus.flags;
            is_int_q    <= bus.int_req;
`endif
            state_q     <= PUSH_HI;
            busy_q      <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= sp_q;
            mem_wdata_q <= bus.ret_pc[31:16];
            done_q      <= 1'b0;
          end
        end
        PUSH_HI: begin
          sp_q        <= sp_q - ADDR_WIDTH'(1);
          state_q     <= PUSH_LO;
          mem_addr_q  <= sp_q - ADDR_WIDTH'(1);
          mem_wdata_q <= pc_q[15:0];
`ifdef PC_PUSH_FLAGS_EN
          done_q      <= !is_int_q;
`else
          done_q      <= 1'b1;
`endif
        end
        PUSH_LO: begin
          sp_q <= sp_q - ADDR_WIDTH'(1);
`ifdef PC_PUSH_FLAGS_EN
          if (is_int_q) begin
            state_q     <= PUSH_FLG;
            mem_addr_q  <= sp_q - ADDR_WIDTH'(1);
            mem_wdata_q <= {12'h000, flags_q};
            done_q      <= 1'b1;
          end else begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
          end
`else
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          done_q      <= 1'b0;
`endif
        end
`ifdef PC_PUSH_FLAGS_EN
        PUSH_FLG: begin
          sp_q        <= sp_q - ADDR_WIDTH'(1);
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          done_q      <= 1'b0;
        end
`endif
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_push_sequencer.sv
// tb_pc_push_sequencer
//   Self-checking bench for pc_push_sequencer. A reference model holds the
//   expected stack pointer and builds each expected frame as a list of
//   (address, word) pairs from the push rules.
//   Optional feature macro: PC_PUSH_FLAGS_EN (interrupt frames gain a flags word).
module tb_pc_push_sequencer;

`ifdef PC_PUSH_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [19:0] sp_m;

  always #5 clk = ~clk;

  pc_push_sequencer_if #(.ADDR_WIDTH(20)) bus ();

  pc_push_sequencer #(.ADDR_WIDTH(20), .SP_RESET(20'hFFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic set_flags(input logic [3:0] f);
`ifdef PC_PUSH_FLAGS_EN
    bus.flags = f;
`else
    if (f === 4'hx) $display("flags ignored");
`endif
  endtask

  // Drive one push request, then compare every write of the frame against
  // the model's expected (address, word) list.
  task automatic run_push(input bit is_int, input logic [31:0] pc,
                          input logic [3:0] f, input bit pop_busy,
                          input string nm);
    int unsigned n;
    logic [19:0] ea[3];
    logic [15:0] ed[3];
    n = (FLG && is_int) ? 3 : 2;
    ed[0] = pc[31:16];
    ed[1] = pc[15:0];
    ed[2] = {12'h000, f};
    for (int unsigned i = 0; i < 3; i++) ea[i] = sp_m - 20'(i);
    @(negedge clk);
    bus.int_req  = is_int;
    bus.call_req = !is_int;
    bus.ret_pc   = pc;
    bus.pop_req  = 1'b0;
    set_flags(f);
    #1;
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++; $display("FAIL %s ack: got %b want 1", nm, bus.ack);
    end
    @(negedge clk);
    bus.int_req  = 1'b0;
    bus.call_req = 1'b0;
    bus.ret_pc   = $urandom;
    set_flags(4'($urandom));
    bus.pop_req  = pop_busy;
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL %s wr%0d: mem_wr=%b busy=%b want 1/1", nm, i, bus.mem_wr, bus.busy);
      end
      checks++;
      if (bus.mem_addr !== ea[i] || bus.mem_wdata !== ed[i]) begin
        errors++; $display("FAIL %s word%0d: got %h@%h want %h@%h", nm, i, bus.mem_wdata, bus.mem_addr, ed[i], ea[i]);
      end
      checks++;
      if (bus.done !== (i == n - 1)) begin
        errors++; $display("FAIL %s done%0d: got %b want %b", nm, i, bus.done, (i == n - 1));
      end
    end
    sp_m = sp_m - 20'(n);
    @(negedge clk);
    bus.pop_req = 1'b0;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sp !== sp_m) begin
      errors++; $display("FAIL %s end: wr=%b busy=%b done=%b sp=%h want 0/0/0 sp=%h", nm, bus.mem_wr, bus.busy, bus.done, bus.sp, sp_m);
    end
  endtask

  task automatic check_reset_state(input string nm);
    checks++;
    if (bus.sp !== 20'hFFFFF || bus.busy !== 1'b0 || bus.mem_wr !== 1'b0 ||
        bus.done !== 1'b0 || bus.ack !== 1'b0 || bus.mem_addr !== 20'h0 || bus.mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL %s: sp=%h busy=%b wr=%b done=%b ack=%b addr=%h data=%h want FFFFF/0/0/0/0/0/0",
               nm, bus.sp, bus.busy, bus.mem_wr, bus.done, bus.ack, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_reset();
    bus.call_req = 1'b0; bus.int_req = 1'b0; bus.pop_req = 1'b0;
    bus.ret_pc = '0; set_flags(4'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sp_m = 20'hFFFFF;
    @(negedge clk);
    check_reset_state("reset");
  endtask

  task automatic test_call();
    run_push(1'b0, 32'h0012_3456, 4'h0, 1'b0, "call");
    checks++;
    if (bus.sp !== 20'hFFFFD) begin
      errors++; $display("FAIL call_sp: got %h want FFFFD", bus.sp);
    end
  endtask

  task automatic test_int();
    run_push(1'b1, 32'hCAFE_BEEF, 4'b1010, 1'b0, "int");
  endtask

  task automatic test_simultaneous();
    int unsigned n;
    logic [31:0] pci, pcc;
    logic [19:0] a0;
    pci = 32'h1111_2222;
    pcc = 32'h3333_4444;
    n = FLG ? 3 : 2;
    a0 = sp_m;
    @(negedge clk);
    bus.int_req = 1'b1; bus.call_req = 1'b1; bus.ret_pc = pci; set_flags(4'h5);
    #1;
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++; $display("FAIL simul ack: got %b want 1", bus.ack);
    end
    @(negedge clk);
    bus.int_req = 1'b0; bus.ret_pc = pcc; set_flags(4'h0);
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.mem_addr !== a0 - 20'(i) || bus.ack !== 1'b0 ||
          bus.mem_wdata !== (i == 0 ? pci[31:16] : i == 1 ? pci[15:0] : 16'h0005)) begin
        errors++; $display("FAIL simul int%0d: wr=%b ack=%b %h@%h", i, bus.mem_wr, bus.ack, bus.mem_wdata, bus.mem_addr);
      end
    end
    sp_m = sp_m - 20'(n);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 1'b1) begin
      errors++; $display("FAIL simul gap: busy=%b ack=%b want 0/1", bus.busy, bus.ack);
    end
    @(negedge clk);
    bus.call_req = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.mem_addr !== sp_m - 20'(i) ||
          bus.mem_wdata !== (i == 0 ? pcc[31:16] : pcc[15:0]) || bus.done !== (i == 1)) begin
        errors++; $display("FAIL simul call%0d: wr=%b done=%b %h@%h", i, bus.mem_wr, bus.done, bus.mem_wdata, bus.mem_addr);
      end
    end
    sp_m = sp_m - 20'd2;
    @(negedge clk);
    checks++;
    if (bus.sp !== sp_m || bus.busy !== 1'b0) begin
      errors++; $display("FAIL simul end: sp=%h busy=%b want %h/0", bus.sp, bus.busy, sp_m);
    end
  endtask

  task automatic test_pop_busy();
    run_push(1'b0, 32'hA5A5_5A5A, 4'h0, 1'b1, "pop_busy_call");
    run_push(1'b1, 32'h0F0F_F0F0, 4'h9, 1'b1, "pop_busy_int");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.call_req = 1'b1; bus.ret_pc = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.call_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sp_m = 20'hFFFFF;
    check_reset_state("reset_mid");
    @(negedge clk);
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.sp !== 20'hFFFFF) begin
      errors++; $display("FAIL reset_mid_after: wr=%b busy=%b sp=%h want 0/0/FFFFF", bus.mem_wr, bus.busy, bus.sp);
    end
  endtask

  task automatic test_pop_wrap();
    // Pop with a call pending: pop wins, nothing is accepted.
    @(negedge clk);
    bus.pop_req = 1'b1; bus.call_req = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++; $display("FAIL pop_prio ack: got %b want 0", bus.ack);
    end
    @(negedge clk);
    bus.pop_req = 1'b0; bus.call_req = 1'b0;
    sp_m = sp_m + 20'd2;
    checks++;
    if (bus.sp !== 20'h00001 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL pop_wrap: sp=%h busy=%b want 00001/0", bus.sp, bus.busy);
    end
    run_push(1'b0, 32'h7654_3210, 4'h0, 1'b0, "wrap_call");
    checks++;
    if (bus.sp !== 20'hFFFFF) begin
      errors++; $display("FAIL wrap_sp: got %h want FFFFF", bus.sp);
    end
    bus.pop_req = 1'b1;
    @(negedge clk);
    bus.pop_req = 1'b0;
    sp_m = sp_m + 20'd2;
    checks++;
    if (bus.sp !== 20'h00001) begin
      errors++; $display("FAIL wrap_pop: got %h want 00001", bus.sp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        bus.pop_req = 1'b1;
        @(negedge clk);
        bus.pop_req = 1'b0;
        sp_m = sp_m + 20'd2;
        checks++;
        if (bus.sp !== sp_m) begin
          errors++; $display("FAIL rand_pop%0d: sp=%h want %h", i, bus.sp, sp_m);
        end
      end
      run_push(1'($urandom), $urandom, 4'($urandom), 1'($urandom), "rand_push");
    end
  endtask

  initial begin
    test_reset();
    test_call();
    test_int();
    test_simultaneous();
    test_pop_busy();
    test_reset_mid();
    test_pop_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_push_sequencer.md
# pc_push_sequencer

Writes the return PC, and optionally the flags, onto the data-memory stack when a CALL or an interrupt is taken. This is the write-side counterpart of the fetch stage's PC pop path, which restores the PC from two 16-bit stack words. The block owns the stack pointer and adjusts it for both pushes and pops, so push and pop always agree on stack layout. It sits between the control unit and the data-memory write port, and stalls fetch through `busy` while a push sequence is running.

## Interface
- `ADDR_WIDTH`, default 20: data-memory address width; also the width of `sp`.
- `SP_RESET`, default 20'hFFFFF: stack-pointer value after reset.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous, active-low.
- `call_req`  in  1: CALL push request; level held until `ack`.
- `int_req`  in  1: interrupt push request; level held until `ack`.
- `ret_pc`  in  32: return address to push; sampled in the accept cycle.
- `flags`  in  4: condition flags; sampled in the accept cycle (used only with `PC_PUSH_FLAGS_EN`).
- `pop_req`  in  1: pop path consumed the two-word PC frame; sp += 2.
- `ack`  out  1: one-cycle pulse in the accept cycle.
- `busy`  out  1: high while state != IDLE; fetch drives pc_enable low while it is high.
- `mem_wr`  out  1: data-memory write strobe.
- `mem_addr`  out  ADDR_WIDTH: write address.
- `mem_wdata`  out  16: write data.
- `sp`  out  ADDR_WIDTH: current stack pointer (next free word).
- `done`  out  1: one-cycle pulse coincident with the final write of a sequence.

## Operation
- FSM states: IDLE, PUSH_HI, PUSH_LO, PUSH_FLG. PUSH_FLG exists only with the macro.
- IDLE, accept rules:
  - `pop_req` has top priority: sp ← sp + 2, no accept that cycle.
  - Otherwise `int_req` is accepted before `call_req`.
  - On accept: `ack`=1; latch `ret_pc`, `flags` and an is_int bit; next state PUSH_HI.
- PUSH_HI: `mem_wr`=1, `mem_addr`=sp, `mem_wdata`=pc_q[31:16]; sp ← sp − 1; next state PUSH_LO.
- PUSH_LO: `mem_wr`=1, `mem_addr`=sp, `mem_wdata`=pc_q[15:0]; sp ← sp − 1.
  - Next state PUSH_FLG if the macro is enabled and is_int=1.
  - Otherwise `done`=1 and next state IDLE.
- PUSH_FLG: `mem_wr`=1, `mem_addr`=sp, `mem_wdata`={12'b0, flags_q}; sp ← sp − 1; `done`=1; next state IDLE.
- Resulting stack layout: low half sits at the lower address, so a pop reads the low half first, then the high half.
- `pop_req` outside IDLE is ignored; control guarantees pops never overlap a push.
- Requests that arrive outside IDLE are not accepted; they stay pending, because requesters hold their level until `ack`.
- sp arithmetic is modulo 2^ADDR_WIDTH:
  - 0 − 1 wraps to all-ones.
  - all-ones + 2 wraps to 1.
  - No overflow or underflow flag.

## Timing
- Reset (rst=0 at a rising edge) sets:
  - state=IDLE, sp=SP_RESET
  - `mem_wr`=0, `ack`=0, `done`=0, `busy`=0
  - `mem_addr`=0, `mem_wdata`=0
- Reset during a sequence aborts it. No further writes occur; any word already written stays in memory.
- All outputs are registered or decoded from registered state only. `ack` is the exception: it is combinational from the requests in IDLE.
- Accept at edge T. Writes follow:
  - PUSH_HI write in cycle T+1.
  - PUSH_LO write in cycle T+2.
  - PUSH_FLG write in cycle T+3, when present.
- `busy` is high for exactly 2 cycles per CALL push, and for 3 cycles per interrupt push when the macro is enabled.
- Back-to-back operation: a request still pending when the FSM returns to IDLE is accepted in that IDLE cycle, giving a minimum 1-cycle gap between sequences.
- `int_req` and `call_req` high together: the interrupt is accepted first and `call_req` stays pending.

## Configuration
- `PC_PUSH_FLAGS_EN` defined:
  - An interrupt push is 3 words (PC high, PC low, flags) and decrements sp by 3.
  - The `flags` port and the PUSH_FLG state are present.
- Not defined:
  - Interrupts and CALLs both push 2 words (sp −2).
  - The `flags` port is omitted and there is no PUSH_FLG state.

## Test plan
- Reset, then check outputs:
  - sp=20'hFFFFF, `busy`=0, `mem_wr`=0 on the cycle after reset release.
  - `rst`=0 asserted mid-sequence returns to this state on the next edge.
- CALL with ret_pc=32'h0012_3456 from sp=20'hFFFFF:
  - Writes 16'h0012 to 20'hFFFFF, then 16'h3456 to 20'hFFFFE.
  - Final sp=20'hFFFFD; `done` pulses with the second write.
- Interrupt with flags=4'b1010 and macro enabled:
  - Writes PC high, PC low, then 16'h000A on three consecutive cycles; sp −3.
  - Without the macro: two writes only, sp −2.
- `int_req` and `call_req` raised in the same IDLE cycle:
  - The interrupt frame is written first.
  - The CALL is accepted in the IDLE cycle right after the first `done`.
- Wrap-around:
  - sp=20'h00001, CALL push → writes at 20'h00001 and 20'h00000; sp=20'hFFFFF.
  - A subsequent `pop_req` → sp=20'h00001.
- `pop_req` while busy is ignored: sp changes only by the push decrements.
